// File: rtl/seq_divider_if.sv
// Handshake and data bundle between the execute stage and the sequential divider.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             busy;
  logic             ready;

  // Pipeline side: issues requests and collects results.
  modport master (
    output start, in1, in2,
    input  quotient, remainder, div_zero, busy, ready
  );

  // Divider side.
  modport slave (
    input  start, in1, in2,
    output quotient, remainder, div_zero, busy, ready
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: one restoring step per cycle on operand magnitudes,
// sign correction applied when the result is published in DONE.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave div
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH:0]   a_q;          // partial remainder, one guard bit for the trial subtract
  logic [WIDTH-1:0] q_q;          // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] d_q;          // divisor magnitude
  logic [CW-1:0]    count_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dz_q;         // divide-by-zero request; q_q then holds the raw dividend
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_zero_q;
  logic             busy_q;
  logic             ready_q;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   a_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  // One restoring-division step and the operand magnitudes for a new request.
  // NOTE: every output gets a value on every path, so no latch can be inferred.
  always_comb begin
    a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial   = a_shift - {1'b0, d_q};
    a_d     = a_shift;
    q_d     = {q_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      a_d = trial;
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end
    // -2^(W-1) negates to itself, which read unsigned is the correct magnitude.
    mag1 = div.in1[WIDTH-1] ? -div.in1 : div.in1;
    mag2 = div.in2[WIDTH-1] ? -div.in2 : div.in2;
  end

  // Control FSM, datapath registers and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      count_q     <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (div.start) begin
            a_q        <= '0;
            d_q        <= mag2;
            count_q    <= '0;
            neg_quo_q  <= div.in1[WIDTH-1] ^ div.in2[WIDTH-1];
            neg_rem_q  <= div.in1[WIDTH-1];
            div_zero_q <= 1'b0;
            if (div.in2 == '0) begin
              q_q     <= div.in1;
              dz_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              q_q     <= mag1;
              dz_q    <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          a_q     <= a_d;
          q_q     <= q_d;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (dz_q) begin
            quotient_q  <= '0;
            remainder_q <= q_q;
            div_zero_q  <= 1'b1;
          end else begin
            quotient_q  <= neg_quo_q ? -q_q : q_q;
            remainder_q <= neg_rem_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
            div_zero_q  <= 1'b0;
          end
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div.quotient  = quotient_q;
  assign div.remainder = remainder_q;
  assign div.div_zero  = div_zero_q;
  assign div.busy      = busy_q;
  assign div.ready     = ready_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: sign combinations, divide-by-zero, overflow,
// ignored restart while busy, and reset in the middle of a divide.
module tb_seq_divider;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_divider_if #(.WIDTH(32)) dv ();

  seq_divider #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .div (dv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one divide and watch it to completion. inj>0 pulses start again,
  // with other operands, before edge inj (counted from the accepting edge).
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input int elat, input int inj);
    int          lat;
    int          pulses;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    @(negedge clk);
    dv.in1   = a;
    dv.in2   = b;
    dv.start = 1'b1;
    @(posedge clk);
    #1 dv.start = 1'b0;
    lat = 0; pulses = 0; q = '0; r = '0; dz = 1'b0;
    for (int n = 1; n <= elat + 3; n++) begin
      if (n == inj) begin
        dv.in1   = 32'd999;
        dv.in2   = 32'd2;
        dv.start = 1'b1;
      end else begin
        dv.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (n == 1 && elat > 1) check({tag, " busy_early"}, 32'(dv.busy), 32'd1);
      if (n == elat - 2 && elat > 3) check({tag, " busy_late"}, 32'(dv.busy), 32'd1);
      if (n == elat) check({tag, " busy_at_ready"}, 32'(dv.busy), 32'd0);
      if (dv.ready) begin
        pulses++;
        if (lat == 0) begin
          lat = n;
          q   = dv.quotient;
          r   = dv.remainder;
          dz  = dv.div_zero;
        end
      end
    end
    dv.start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " pulses"}, 32'(pulses), 32'd1);
    check({tag, " quotient"}, q, eq);
    check({tag, " remainder"}, r, er);
    check({tag, " div_zero"}, 32'(dz), 32'(edz));
    check({tag, " hold_q"}, dv.quotient, eq);
  endtask

  initial begin
    int pulses;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    dv.start = 1'b0;
    dv.in1   = '0;
    dv.in2   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst quotient", dv.quotient, 32'd0);
    check("rst remainder", dv.remainder, 32'd0);
    check("rst div_zero", 32'(dv.div_zero), 32'd0);
    check("rst busy", 32'(dv.busy), 32'd0);
    check("rst ready", 32'(dv.ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div("pos_pos", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 0);
    do_div("neg_pos", -32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 33, 0);
    do_div("pos_neg", 32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 33, 0);
    do_div("neg_neg", -32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 33, 0);
    do_div("small", 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 33, 0);
    do_div("dz", 32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1, 0);
    do_div("dz_clear", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 33, 0);
    do_div("dz_neg", 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, 0);
    do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, 0);
    do_div("min_by_1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33, 0);
    do_div("restart", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 10);

    // Reset in the middle of a divide: abandoned, no ready afterwards.
    @(negedge clk);
    dv.in1   = 32'd1000;
    dv.in2   = 32'd3;
    dv.start = 1'b1;
    @(posedge clk);
    #1 dv.start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst busy", 32'(dv.busy), 32'd0);
    check("mid_rst quotient", dv.quotient, 32'd0);
    check("mid_rst remainder", dv.remainder, 32'd0);
    check("mid_rst ready", 32'(dv.ready), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (dv.ready) pulses++;
    end
    check("mid_rst no_ready", 32'(pulses), 32'd0);
    do_div("after_rst", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
